ioctl_upload_reader: RTL and testbench

//  Return path of the HPS ioctl channel: serves ioctl_rd byte reads (NVRAM/hiscore

---
 rtl/ioctl_pkg.sv | 11 +
 rtl/ioctl_upload_reader_if.sv | 11 +
 rtl/toggle_sync.sv | 14 +
 rtl/ioctl_upload_reader.sv | 115 +++++++++++
 tb/tb_ioctl_upload_reader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ioctl_pkg.sv
// Shared types for the HPS ioctl download/upload paths.
package ioctl_pkg;
  localparam int IOCTL_AW = 25;
  localparam int MEM_AW   = 23;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} upl_state_t;

  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/ioctl_upload_reader_if.sv
// SDRAM port1 toggle req/ack bus as seen by the ioctl upload reader.
interface ioctl_upload_reader_if;
  import ioctl_pkg::*;
  logic              mem_req;
  logic              mem_ack;
  logic [MEM_AW-1:0] mem_a;
  logic [15:0]       mem_q;

  modport master (output mem_req, output mem_a, input mem_ack, input mem_q);
  modport slave  (input mem_req, input mem_a, output mem_ack, output mem_q);
endinterface

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a toggle handshake signal; clears to 0 on reset.
module toggle_sync (
  input  logic clk_sys,
  input  logic RESET,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk_sys) begin
    if (RESET) {q, meta} <= 2'b00;
    else       {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves ioctl_rd byte reads from SDRAM port1 during an upload session,
// with a one-word cache so the odd byte of a word costs no extra access.
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter logic [IOCTL_AW-1:0] ADDR_BASE  = 25'h0,
  parameter logic [IOCTL_AW-1:0] ADDR_LIMIT = 25'h10000,
  parameter int                  TIMEOUT    = 255
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic                 ioctl_upload,
  input  logic                 ioctl_rd,
  input  logic [IOCTL_AW-1:0]  ioctl_addr,
  output logic [7:0]           ioctl_din,
  output logic                 ioctl_wait,
  ioctl_upload_reader_if.master mem,
  output logic                 busy,
  output logic                 err
);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  upl_state_t        state;
  logic              ack_s, upload_d, cache_v, byte_hi, stale;
  logic [MEM_AW-1:0] tag;
  logic [15:0]       cache_w;
  logic [CW-1:0]     cnt;
  logic [MEM_AW:0]   ba;
  logic              upl_rise, hit, over;
  logic [7:0]        hit_byte, rd_byte;

  // Carries above bit 23 are dropped so mem_a wraps at 16 MB.
  assign ba       = (MEM_AW + 1)'(ioctl_addr + ADDR_BASE);
  assign over     = ioctl_addr >= ADDR_LIMIT;
  assign upl_rise = ioctl_upload & ~upload_d;
  assign hit      = cache_v & ~upl_rise & (tag == ba[MEM_AW:1]);
  assign hit_byte = word_byte(cache_w, ba[0]);
  assign rd_byte  = word_byte(mem.mem_q, byte_hi);
  assign busy     = state != IDLE;

  toggle_sync u_ack_sync (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .d       (mem.mem_ack),
    .q       (ack_s)
  );

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state       <= IDLE;
      ioctl_din   <= 8'hFF;
      ioctl_wait  <= 1'b0;
      mem.mem_req <= 1'b0;
      mem.mem_a   <= '0;
      err         <= 1'b0;
      cache_v     <= 1'b0;
      tag         <= '0;
      cache_w     <= '0;
      byte_hi     <= 1'b0;
      stale       <= 1'b0;
      cnt         <= '0;
      upload_d    <= 1'b0;
    end else begin
      upload_d <= ioctl_upload;
      if (upl_rise) begin
        cache_v <= 1'b0;
        err     <= 1'b0;
      end
      case (state)
        IDLE: if (ioctl_rd && ioctl_upload) begin
          if (over)     ioctl_din <= 8'hFF;
          else if (hit) ioctl_din <= hit_byte;
          else begin
            mem.mem_a  <= ba[MEM_AW:1];
            byte_hi    <= ba[0];
            ioctl_wait <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          cnt   <= '0;
          state <= WAIT;
          // An ack from an aborted fetch is still in flight: drain it first.
          if (mem.mem_req != ack_s) stale <= 1'b1;
          else                      mem.mem_req <= ~mem.mem_req;
        end
        WAIT: begin
          if (mem.mem_req == ack_s) begin
            if (stale) begin
              stale <= 1'b0;
              state <= REQ;
            end else begin
              cache_w    <= mem.mem_q;
              tag        <= mem.mem_a;
              cache_v    <= 1'b1;
              ioctl_din  <= rd_byte;
              ioctl_wait <= 1'b0;
              state      <= IDLE;
            end
          end else if (cnt == CW'(TIMEOUT)) begin
            ioctl_din  <= 8'hFF;
            err        <= 1'b1;
            cache_v    <= 1'b0;
            ioctl_wait <= 1'b0;
            stale      <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed + random reads against two reader instances and toggle-responder sdram models.
module tb_ioctl_upload_reader;
  import ioctl_pkg::*;

  localparam logic [24:0] LIM_A  = 25'h100;
  localparam logic [24:0] BASE_B = 25'h32000;
  localparam logic [24:0] LIM_B  = 25'h1000000;
  localparam int          TMO    = 255;
  localparam int          BOUND  = 600;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic        upl = 1'b0, rd_a = 1'b0, rd_b = 1'b0;
  logic [24:0] addr_a = '0, addr_b = '0;
  logic [7:0]  din_a, din_b;
  logic        wait_a, wait_b, busy_a, busy_b, err_a, err_b;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_reader_if mif_a ();
  ioctl_upload_reader_if mif_b ();

  ioctl_upload_reader #(.ADDR_BASE(25'h0), .ADDR_LIMIT(LIM_A), .TIMEOUT(TMO)) dut_a (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl_upload(upl), .ioctl_rd(rd_a),
    .ioctl_addr(addr_a), .ioctl_din(din_a), .ioctl_wait(wait_a), .mem(mif_a),
    .busy(busy_a), .err(err_a));

  ioctl_upload_reader #(.ADDR_BASE(BASE_B), .ADDR_LIMIT(LIM_B), .TIMEOUT(TMO)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl_upload(upl), .ioctl_rd(rd_b),
    .ioctl_addr(addr_b), .ioctl_din(din_b), .ioctl_wait(wait_b), .mem(mif_b),
    .busy(busy_b), .err(err_b));

  // Word memory contents derived from the word address.
  function automatic logic [15:0] mdata(input logic [22:0] w);
    if (w == 23'h0) return 16'hBEEF;
    return w[15:0] ^ {w[7:0], w[22:15]} ^ 16'h3C5A;
  endfunction

  // sdram port1 responders: 3-10 cycle latency; A can withhold its ack.
  bit          hold_a = 1'b0;
  logic        seen_a = 1'b0, seen_b = 1'b0;
  logic [22:0] ra_a = '0, ra_b = '0;
  int          lat_a = 0, lat_b = 0;

  always @(posedge clk_sys) begin
    if (RESET) begin
      mif_a.mem_ack <= 1'b0; mif_a.mem_q <= '0; seen_a <= 1'b0; lat_a <= 0;
    end else if (lat_a == 0) begin
      if (mif_a.mem_req != seen_a) begin
        seen_a <= mif_a.mem_req; ra_a <= mif_a.mem_a; lat_a <= int'($urandom_range(3, 10));
      end
    end else if (lat_a == 1) begin
      if (!hold_a) begin
        mif_a.mem_q <= mdata(ra_a); mif_a.mem_ack <= ~mif_a.mem_ack; lat_a <= 0;
      end
    end else lat_a <= lat_a - 1;
  end

  always @(posedge clk_sys) begin
    if (RESET) begin
      mif_b.mem_ack <= 1'b0; mif_b.mem_q <= '0; seen_b <= 1'b0; lat_b <= 0;
    end else if (lat_b == 0) begin
      if (mif_b.mem_req != seen_b) begin
        seen_b <= mif_b.mem_req; ra_b <= mif_b.mem_a; lat_b <= int'($urandom_range(3, 10));
      end
    end else if (lat_b == 1) begin
      mif_b.mem_q <= mdata(ra_b); mif_b.mem_ack <= ~mif_b.mem_ack; lat_b <= 0;
    end else lat_b <= lat_b - 1;
  end

  // Request toggle counters.
  logic pr_a = 1'b0, pr_b = 1'b0;
  int   tog_a = 0, tog_b = 0;
  always @(posedge clk_sys) begin
    pr_a <= mif_a.mem_req;
    pr_b <= mif_b.mem_req;
    if (pr_a !== mif_a.mem_req) tog_a <= tog_a + 1;
    if (pr_b !== mif_b.mem_req) tog_b <= tog_b + 1;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: which word each reader should be holding.
  bit          mv [2];
  logic [22:0] mt [2];

  task automatic do_rd(input bit b, input logic [24:0] a, output logic [7:0] d,
                       output bit waited, output int ntog, output bit tmo);
    int t0, n;
    t0 = b ? tog_b : tog_a;
    @(negedge clk_sys);
    if (b) begin rd_b = 1'b1; addr_b = a; end
    else   begin rd_a = 1'b1; addr_a = a; end
    @(negedge clk_sys);
    rd_a = 1'b0; rd_b = 1'b0;
    waited = b ? wait_b : wait_a;
    n = 0;
    while ((b ? wait_b : wait_a) && n < BOUND) begin @(negedge clk_sys); n++; end
    tmo = (n >= BOUND);
    @(negedge clk_sys);
    d    = b ? din_b : din_a;
    ntog = (b ? tog_b : tog_a) - t0;
  endtask

  task automatic mrd(input bit b, input logic [24:0] a, input string tag);
    logic [7:0]  d, exp_d;
    logic [15:0] wd;
    logic [22:0] idx;
    bit          waited, tmo, exp_w;
    int          ntog, exp_t;
    longint      s;
    if (a >= (b ? LIM_B : LIM_A)) begin
      exp_d = 8'hFF; exp_w = 1'b0; exp_t = 0;
    end else begin
      s     = (longint'(a) + longint'(b ? BASE_B : 25'h0)) % 64'h1000000;
      idx   = 23'(s / 2);
      wd    = mdata(idx);
      exp_d = (s % 2 == 1) ? wd[15:8] : wd[7:0];
      if (mv[b] && mt[b] == idx) begin
        exp_w = 1'b0; exp_t = 0;
      end else begin
        exp_w = 1'b1; exp_t = 1; mv[b] = 1'b1; mt[b] = idx;
      end
    end
    do_rd(b, a, d, waited, ntog, tmo);
    chk({tag, ".bound"}, 32'(tmo), 32'd0);
    chk({tag, ".din"},   32'(d), 32'(exp_d));
    chk({tag, ".wait"},  32'(waited), 32'(exp_w));
    chk({tag, ".tog"},   32'(ntog), 32'(exp_t));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic [24:0] a, last;
    bit          waited, tmo, b;
    int          ntog, t0, n;

    mv[0] = 1'b0; mv[1] = 1'b0; mt[0] = '0; mt[1] = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst.din",  32'(din_a), 32'hFF);
    chk("rst.wait", 32'(wait_a), 32'd0);
    chk("rst.req",  32'(mif_a.mem_req), 32'd0);
    chk("rst.a",    32'(mif_a.mem_a), 32'd0);
    chk("rst.busy", 32'(busy_a), 32'd0);
    chk("rst.err",  32'(err_a), 32'd0);
    RESET = 1'b0;
    upl   = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Word fetch, then odd byte from the cache.
    mrd(0, 25'h0, "s1.rd0");
    chk("s1.ef", 32'(din_a), 32'hEF);
    mrd(0, 25'h1, "s1.rd1");
    chk("s1.be", 32'(din_a), 32'hBE);

    // Tag replacement.
    mrd(0, 25'h2, "s2.rd2");  chk("s2.a1", 32'(mif_a.mem_a), 32'd1);
    mrd(0, 25'h4, "s2.rd4");  chk("s2.a2", 32'(mif_a.mem_a), 32'd2);
    mrd(0, 25'h3, "s2.rd3");  chk("s2.a1b", 32'(mif_a.mem_a), 32'd1);

    // Above the upload limit.
    mrd(0, 25'h100, "s3.lim");
    mrd(0, 25'h1FF, "s3.lim2");

    // Withheld ack: timeout, then a stalled read served by a fresh toggle.
    hold_a = 1'b1;
    do_rd(0, 25'h20, d, waited, ntog, tmo);
    mv[0] = 1'b0;
    chk("s4.bound", 32'(tmo), 32'd0);
    chk("s4.wait",  32'(waited), 32'd1);
    chk("s4.din",   32'(d), 32'hFF);
    chk("s4.err",   32'(err_a), 32'd1);
    chk("s4.tog",   32'(ntog), 32'd1);
    t0 = tog_a;
    @(negedge clk_sys); rd_a = 1'b1; addr_a = 25'h31;
    @(negedge clk_sys); rd_a = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("s4.stall_w", 32'(wait_a), 32'd1);
    chk("s4.stall_t", 32'(tog_a - t0), 32'd0);
    hold_a = 1'b0;
    n = 0;
    while (wait_a && n < BOUND) begin @(negedge clk_sys); n++; end
    @(negedge clk_sys);
    chk("s4.bound2", 32'(n >= BOUND), 32'd0);
    chk("s4.din2",   32'(din_a), 32'(mdata(23'h18) >> 8));
    chk("s4.tog2",   32'(tog_a - t0), 32'd1);
    chk("s4.sticky", 32'(err_a), 32'd1);
    mv[0] = 1'b1; mt[0] = 23'h18;
    mrd(0, 25'h30, "s4.hit");
    upl = 1'b0; repeat (2) @(negedge clk_sys);
    upl = 1'b1; repeat (2) @(negedge clk_sys);
    mv[0] = 1'b0; mv[1] = 1'b0;
    chk("s4.errclr", 32'(err_a), 32'd0);

    // Reset during WAIT.
    @(negedge clk_sys); rd_a = 1'b1; addr_a = 25'h40;
    @(negedge clk_sys); rd_a = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("s5.busy0", 32'(busy_a), 32'd1);
    RESET = 1'b1;
    @(negedge clk_sys);
    chk("s5.busy", 32'(busy_a), 32'd0);
    chk("s5.wait", 32'(wait_a), 32'd0);
    chk("s5.req",  32'(mif_a.mem_req), 32'd0);
    chk("s5.din",  32'(din_a), 32'hFF);
    RESET = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0;
    repeat (3) @(negedge clk_sys);
    mrd(0, 25'h40, "s5.after");

    // Base offset and 16 MB wrap on B.
    mrd(1, 25'h1, "s6.rd1");
    chk("s6.a",    32'(mif_b.mem_a), 32'h19000);
    chk("s6.din",  32'(din_b), 32'(mdata(23'h19000) >> 8));
    mrd(1, 25'hFD0000, "s6.wrap");
    chk("s6.awrap", 32'(mif_b.mem_a), 32'h1000);
    chk("s6.busy",  32'(busy_b), 32'd0);
    chk("s6.err",   32'(err_b), 32'd0);

    // Random reads, biased towards the partner byte of the last address.
    last = '0;
    repeat (60) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) a = last ^ 25'h1;
      else if (!b) a = 25'($urandom_range(0, 'h1FF));
      else begin
        a = 25'($urandom_range(0, 'h3FF));
        case ($urandom_range(0, 5))
          0: a = a | 25'hFFF000;
          1: a = a | LIM_B;
          default: ;
        endcase
      end
      mrd(b, a, b ? "rnd.b" : "rnd.a");
      last = a;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
